// File: rtl/clocked_oneshot_bank_if.sv
// -----------------------------------------------------------------------------
// clocked_oneshot_bank_if
// Bundles the trigger inputs, shared configuration and per-channel status of
// the clocked one-shot bank so the block can be wired up as a single port.
//
// Signals:
//   input_pulse  [CHANNELS]  per-channel asynchronous trigger inputs
//   edge_sel     [2]         00 falling, 01 rising, 10 both, 11 triggers off
//   pulse_len    [CNT_BITS]  pulse length in cycles (0 behaves as 1)
//   retrigger    [1]         trigger during a pulse extends it
//   overrun_clr  [1]         synchronous clear of all overrun flags
//   one_shot     [CHANNELS]  registered pulse outputs
//   busy         [CHANNELS]  channel is pulsing or in its recovery cycle
//   overrun      [CHANNELS]  sticky "a trigger was dropped" flags
//
// Modports: master drives triggers/configuration, slave is the one-shot bank.
// -----------------------------------------------------------------------------
interface clocked_oneshot_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_BITS = 8
);
    logic [CHANNELS-1:0] input_pulse;
    logic [1:0]          edge_sel;
    logic [CNT_BITS-1:0] pulse_len;
    logic                retrigger;
    logic                overrun_clr;
    logic [CHANNELS-1:0] one_shot;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] overrun;

    modport master (
        output input_pulse, edge_sel, pulse_len, retrigger, overrun_clr,
        input  one_shot, busy, overrun
    );

    modport slave (
        input  input_pulse, edge_sel, pulse_len, retrigger, overrun_clr,
        output one_shot, busy, overrun
    );
endinterface

// File: rtl/clocked_oneshot_bank.sv
// -----------------------------------------------------------------------------
// clocked_oneshot_bank
// Multi-channel clocked one-shot generator. Each channel synchronises its
// input, detects the selected edge and emits a pulse of programmable width
// and polarity, with optional retrigger/extend and a sticky overrun flag.
//
// Ports:
//   clk    rising-edge clock for all logic
//   rst_n  asynchronous active-low reset
//   bus    clocked_oneshot_bank_if.slave (triggers, configuration, status)
//
// Parameters:
//   CHANNELS        number of independent channels (1..32)
//   CNT_BITS        width of pulse_len and of each channel's down-counter
//   SYNC_STAGES     synchroniser depth (0 = input already synchronous)
//   OUT_ACTIVE_LOW  1 = one_shot active level is 0, idle is 1
// -----------------------------------------------------------------------------
module clocked_oneshot_bank #(
    parameter int CHANNELS       = 4,
    parameter int CNT_BITS       = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int OUT_ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    clocked_oneshot_bank_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PULSE   = 2'b01,
        RECOVER = 2'b10
    } state_t;

    localparam logic                ACTIVE_LEVEL = (OUT_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [CNT_BITS-1:0] ONE          = CNT_BITS'(1);

    logic                primed;
    logic [CNT_BITS-1:0] load_len;
    logic [CHANNELS-1:0] one_shot_vec;
    logic [CHANNELS-1:0] busy_vec;
    logic [CHANNELS-1:0] overrun_vec;

    // A zero length would otherwise produce no pulse at all, so it is
    // promoted to a single cycle.
    assign load_len = (bus.pulse_len == '0) ? ONE : bus.pulse_len;

    // The first cycle after reset only loads the previous-sample flops, so the
    // reset-time input level can never be mistaken for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic                sync_val;
        logic                prev_val;
        logic                trig;
        logic                drop;
        state_t              state;
        state_t              state_next;
        logic [CNT_BITS-1:0] cnt;
        logic [CNT_BITS-1:0] cnt_next;
        logic                one_shot_q;
        logic                busy_q;
        logic                overrun_q;

        if (SYNC_STAGES == 0) begin : g_raw
            assign sync_val = bus.input_pulse[i];
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain;

            // Plain flop chain bringing the asynchronous input into the clock
            // domain; the last stage is the only one the logic looks at.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain <= '0;
                end else begin
                    chain[0] <= bus.input_pulse[i];
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        chain[s] <= chain[s-1];
                    end
                end
            end

            assign sync_val = chain[SYNC_STAGES-1];
        end

        // Previous synchronised sample, compared against the current one to
        // find transitions.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_val <= 1'b0;
            end else begin
                prev_val <= sync_val;
            end
        end

        // Edge detector: only the transition direction chosen by edge_sel
        // counts, and nothing counts until the priming cycle has passed.
        always_comb begin
            trig = 1'b0;
            if (primed) begin
                case (bus.edge_sel)
                    2'b00:   trig = prev_val & ~sync_val;
                    2'b01:   trig = ~prev_val & sync_val;
                    2'b10:   trig = prev_val ^ sync_val;
                    default: trig = 1'b0;
                endcase
            end
        end

        // Channel state, counter and registered outputs. Outputs are decoded
        // from the next state so they change on the same edge as the state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state      <= IDLE;
                cnt        <= '0;
                one_shot_q <= ~ACTIVE_LEVEL;
                busy_q     <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                state      <= state_next;
                cnt        <= cnt_next;
                one_shot_q <= (state_next == PULSE) ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
                busy_q     <= (state_next != IDLE);
                if (drop) begin
                    overrun_q <= 1'b1;
                end else if (bus.overrun_clr) begin
                    overrun_q <= 1'b0;
                end
            end
        end

        // Next-state logic. The counter holds the number of active cycles
        // still to come including the current one, so the pulse ends when it
        // reads one; the <= test keeps it from ever wrapping below zero.
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            drop       = 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        state_next = PULSE;
                        cnt_next   = load_len;
                    end
                end
                PULSE: begin
                    if (trig && bus.retrigger) begin
                        cnt_next = load_len;
                    end else begin
                        drop = trig;
                        if (cnt <= ONE) begin
                            state_next = RECOVER;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt - ONE;
                        end
                    end
                end
                RECOVER: begin
                    if (trig) begin
                        state_next = PULSE;
                        cnt_next   = load_len;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        assign one_shot_vec[i] = one_shot_q;
        assign busy_vec[i]     = busy_q;
        assign overrun_vec[i]  = overrun_q;
    end

    assign bus.one_shot = one_shot_vec;
    assign bus.busy     = busy_vec;
    assign bus.overrun  = overrun_vec;

endmodule

// File: tb/tb_clocked_oneshot_bank.sv
// -----------------------------------------------------------------------------
// tb_clocked_oneshot_bank
// Self-checking bench for clocked_oneshot_bank (4 channels, 8-bit counter,
// two synchroniser stages, active-low outputs). A timestamp-based reference
// model predicts every channel's outputs after each rising edge.
// -----------------------------------------------------------------------------
module tb_clocked_oneshot_bank;

    localparam int CH   = 4;
    localparam int CB   = 8;
    localparam int SYNC = 2;
    localparam int HMAX = 16384;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clocked_oneshot_bank_if #(.CHANNELS(CH), .CNT_BITS(CB)) bus ();

    clocked_oneshot_bank #(
        .CHANNELS(CH),
        .CNT_BITS(CB),
        .SYNC_STAGES(SYNC),
        .OUT_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: input samples per edge, and each channel's current
    // pulse as a [startT, endT] window of edge numbers.
    int          edgeCount;
    logic        hist [CH][HMAX];
    int          startT [CH];
    int          endT [CH];
    logic [CH-1:0] ovModel;

    int activeCount0;
    int otherActive;

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic inAt(input int ch, input int m);
        if (m <= 0) return 1'b0;
        return hist[ch][m];
    endfunction

    task automatic modelReset();
        edgeCount = 0;
        for (int c = 0; c < CH; c++) begin
            startT[c] = 0;
            endT[c]   = -10;
        end
        ovModel = '0;
    endtask

    // Advances the model by one rising edge using the inputs seen at it.
    task automatic modelStep();
        int   m;
        int   len;
        logic p;
        logic q;
        logic trig;
        logic wasActive;
        logic drop;
        edgeCount++;
        m   = edgeCount;
        len = (bus.pulse_len == 0) ? 1 : int'(bus.pulse_len);
        for (int c = 0; c < CH; c++) begin
            hist[c][m] = bus.input_pulse[c];
            p = inAt(c, m - 1 - SYNC);
            q = inAt(c, m - SYNC);
            case (bus.edge_sel)
                2'b00:   trig = p && !q;
                2'b01:   trig = !p && q;
                2'b10:   trig = p != q;
                default: trig = 1'b0;
            endcase
            if (m < 2) trig = 1'b0;
            wasActive = (startT[c] <= m - 1) && (m - 1 <= endT[c]);
            drop = 1'b0;
            if (trig) begin
                if (wasActive) begin
                    if (bus.retrigger) endT[c] = m + len - 1;
                    else drop = 1'b1;
                end else begin
                    startT[c] = m;
                    endT[c]   = m + len - 1;
                end
            end
            if (drop) ovModel[c] = 1'b1;
            else if (bus.overrun_clr) ovModel[c] = 1'b0;
        end
    endtask

    task automatic compareAll();
        logic [CH-1:0] expOs;
        logic [CH-1:0] expBusy;
        logic          act;
        for (int c = 0; c < CH; c++) begin
            act        = (startT[c] <= edgeCount) && (edgeCount <= endT[c]);
            expOs[c]   = !act;
            expBusy[c] = act || (edgeCount == endT[c] + 1);
        end
        checkOutput("one_shot", 32'(bus.one_shot), 32'(expOs));
        checkOutput("busy", 32'(bus.busy), 32'(expBusy));
        checkOutput("overrun", 32'(bus.overrun), 32'(ovModel));
    endtask

    // Drives one input pattern for a number of cycles, stepping the model
    // and comparing outputs after every edge.
    task automatic applyStimulus(input logic [CH-1:0] pin, input logic clr, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            bus.input_pulse = pin;
            bus.overrun_clr = clr;
            @(posedge clk);
            modelStep();
            #1;
            compareAll();
            if (bus.one_shot[0] == 1'b0) activeCount0++;
            if (bus.one_shot[CH-1:1] != '1) otherActive++;
        end
    endtask

    logic [CH-1:0] level;

    initial begin
        bus.input_pulse = '0;
        bus.edge_sel    = 2'b00;
        bus.pulse_len   = 8'd1;
        bus.retrigger   = 1'b0;
        bus.overrun_clr = 1'b0;
        level           = '0;
        modelReset();

        #12;
        checkOutput("reset_one_shot", 32'(bus.one_shot), 32'h0000_000F);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        checkOutput("reset_overrun", 32'(bus.overrun), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        $display("[TB] falling edge, L=1, priming after reset");
        activeCount0 = 0;
        applyStimulus(4'b0001, 1'b0, 4);
        applyStimulus(4'b0000, 1'b0, 6);
        checkOutput("fall_width_L1", 32'(activeCount0), 32'd1);

        $display("[TB] rising edge, L=5, back-to-back");
        bus.edge_sel  = 2'b01;
        bus.pulse_len = 8'd5;
        activeCount0  = 0;
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 5);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 12);
        checkOutput("pulse5_width", 32'(activeCount0), 32'd10);
        checkOutput("pulse5_overrun", 32'(bus.overrun[0]), 32'd0);

        $display("[TB] L=8 without retrigger, dropped trigger");
        bus.pulse_len = 8'd8;
        bus.retrigger = 1'b0;
        activeCount0  = 0;
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 2);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 12);
        checkOutput("drop_width", 32'(activeCount0), 32'd8);
        checkOutput("drop_overrun", 32'(bus.overrun[0]), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1);
        checkOutput("overrun_cleared", 32'(bus.overrun[0]), 32'd0);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 2);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1);
        applyStimulus(4'b0000, 1'b1, 1);
        applyStimulus(4'b0000, 1'b0, 10);
        checkOutput("overrun_set_wins", 32'(bus.overrun[0]), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1);

        $display("[TB] L=8 with retrigger at active cycle 4");
        bus.retrigger = 1'b1;
        activeCount0  = 0;
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 3);
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 20);
        checkOutput("retrig_width", 32'(activeCount0), 32'd12);
        checkOutput("retrig_overrun", 32'(bus.overrun[0]), 32'd0);

        $display("[TB] both edges, L=0, then triggers disabled mid-pulse");
        bus.edge_sel  = 2'b10;
        bus.pulse_len = 8'd0;
        bus.retrigger = 1'b0;
        activeCount0  = 0;
        otherActive   = 0;
        level         = '0;
        for (int t = 0; t < 4; t++) begin
            level[0] = ~level[0];
            applyStimulus(level, 1'b0, 20);
        end
        checkOutput("toggle_pulses", 32'(activeCount0), 32'd4);
        checkOutput("other_channels_idle", 32'(otherActive), 32'd0);
        bus.pulse_len = 8'd6;
        activeCount0  = 0;
        applyStimulus(4'b0001, 1'b0, 4);
        bus.edge_sel = 2'b11;
        applyStimulus(4'b0000, 1'b0, 3);
        applyStimulus(4'b0001, 1'b0, 3);
        applyStimulus(4'b0000, 1'b0, 10);
        checkOutput("disabled_completes", 32'(activeCount0), 32'd6);

        $display("[TB] maximum pulse length");
        bus.edge_sel  = 2'b01;
        bus.pulse_len = 8'd255;
        activeCount0  = 0;
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 262);
        checkOutput("max_len_width", 32'(activeCount0), 32'd255);

        $display("[TB] reset in pulse cycle 3 of 10");
        bus.pulse_len = 8'd10;
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_one_shot", 32'(bus.one_shot), 32'h0000_000F);
        checkOutput("midreset_busy", 32'(bus.busy), 32'h0);
        modelReset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        activeCount0 = 0;
        applyStimulus(4'b0000, 1'b0, 15);
        checkOutput("no_resume", 32'(activeCount0), 32'd0);

        $display("[TB] randomized traffic");
        level = '0;
        for (int n = 0; n < 1500; n++) begin
            logic clr;
            if ($urandom_range(0, 5) == 0) level = level ^ (4'b0001 << $urandom_range(0, CH - 1));
            if ($urandom_range(0, 49) == 0) bus.edge_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) bus.pulse_len = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) bus.retrigger = ~bus.retrigger;
            clr = ($urandom_range(0, 24) == 0);
            applyStimulus(level, clr, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
